// File: rtl/qdec_pkg.sv
// qdec_pkg: shared types and helpers for the quadrature encoder decoder.
// Phase encoding equals the filtered {a,b} pair so a plain cast maps
// channel bits to a phase.
package qdec_pkg;

    typedef enum logic [1:0] {
        PH_11 = 2'b11,
        PH_01 = 2'b01,
        PH_00 = 2'b00,
        PH_10 = 2'b10
    } phase_t;

    typedef logic signed [3:0] substep_t;

    typedef enum logic [1:0] {
        DIR_NONE    = 2'd0,
        DIR_CW      = 2'd1,
        DIR_CCW     = 2'd2,
        DIR_ILLEGAL = 2'd3
    } dir_t;

    localparam int STEPS_PER_DETENT = 4;

    // Position of a phase along the clockwise cycle 11 -> 01 -> 00 -> 10.
    function automatic logic [1:0] phase_pos(input phase_t ph);
        logic [1:0] pos;
        case (ph)
            PH_11:   pos = 2'd0;
            PH_01:   pos = 2'd1;
            PH_00:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    // Direction of a phase change: one position forward is CW, one back is
    // CCW, two positions (both bits toggled) cannot be resolved.
    function automatic dir_t qdec_dir(input phase_t prev, input phase_t cur);
        logic [1:0] delta;
        dir_t       dir;
        delta = phase_pos(cur) - phase_pos(prev);
        case (delta)
            2'd0:    dir = DIR_NONE;
            2'd1:    dir = DIR_CW;
            2'd3:    dir = DIR_CCW;
            default: dir = DIR_ILLEGAL;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/quad_encoder_decoder_if.sv
// quad_encoder_decoder_if: encoder inputs, load port and decoded outputs.
// master = host side (drives encoder and load), slave = decoder.
interface quad_encoder_decoder_if #(
    parameter int unsigned CNT_W = 8
);
    logic             enc_a;
    logic             enc_b;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             step_cw;
    logic             step_ccw;
    logic             err;
    logic [CNT_W-1:0] value;
    logic             at_min;
    logic             at_max;

    modport master (
        output enc_a, enc_b, load, load_val,
        input  step_cw, step_ccw, err, value, at_min, at_max
    );

    modport slave (
        input  enc_a, enc_b, load, load_val,
        output step_cw, step_ccw, err, value, at_min, at_max
    );
endinterface

// File: rtl/qdec_debounce.sv
// qdec_debounce: one encoder channel, 2-flop synchronizer followed by a
// stability filter. The filtered output only follows the synchronized input
// after it has disagreed for DEBOUNCE_CYC consecutive clocks. All flops
// reset high to match the pulled-up idle state.
module qdec_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filtered
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          filt_reg;
    logic [CW-1:0] cnt_reg;

    // Synchronize, count disagreeing clocks, flip the filter on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            filt_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg == filt_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                filt_reg <= sync2_reg;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign filtered = filt_reg;
endmodule

// File: rtl/quad_encoder_decoder.sv
// quad_encoder_decoder: debounces a mechanical quadrature encoder, counts
// sub-steps between detents and turns each full detent into a step pulse
// plus a bounded position update.
// Optional build macro QDEC_WRAP_EN: value wraps between MIN_VAL and MAX_VAL
// instead of saturating.
module quad_encoder_decoder #(
    parameter int                DEBOUNCE_CYC = 16,
    parameter int unsigned       CNT_W        = 8,
    parameter logic [CNT_W-1:0]  MIN_VAL      = '0,
    parameter logic [CNT_W-1:0]  MAX_VAL      = '1,
    parameter logic [CNT_W-1:0]  INIT_VAL     = '0
) (
    input logic                    clk,
    input logic                    rst,
    quad_encoder_decoder_if.slave  bus
);
    import qdec_pkg::*;

    logic [1:0]       raw_ab;
    logic [1:0]       filt_ab;
    phase_t           cur_ph;
    phase_t           prev_reg;
    dir_t             dir;
    substep_t         acc_reg;
    substep_t         acc_next;
    logic             cw_next;
    logic             ccw_next;
    logic             err_next;
    logic             step_cw_reg;
    logic             step_ccw_reg;
    logic             err_reg;
    logic [CNT_W-1:0] value_reg;
    logic [CNT_W-1:0] value_next;
    logic             at_min_reg;
    logic             at_max_reg;

    assign raw_ab = {bus.enc_a, bus.enc_b};

    // One debounce channel per encoder line; bit 1 = A, bit 0 = B.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            qdec_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_debounce (
                .clk      (clk),
                .rst      (rst),
                .raw      (raw_ab[gi]),
                .filtered (filt_ab[gi])
            );
        end
    endgenerate

    assign cur_ph = phase_t'(filt_ab);

    // Sub-step accounting: direction of the latest filtered phase change,
    // detent check whenever a legal move lands on phase 11.
    always_comb begin
        dir      = qdec_dir(prev_reg, cur_ph);
        acc_next = acc_reg;
        cw_next  = 1'b0;
        ccw_next = 1'b0;
        err_next = 1'b0;
        case (dir)
            DIR_CW:      acc_next = acc_reg + substep_t'(1);
            DIR_CCW:     acc_next = acc_reg - substep_t'(1);
            DIR_ILLEGAL: begin
                err_next = 1'b1;
                acc_next = '0;
            end
            default:     ;
        endcase
        if (((dir == DIR_CW) || (dir == DIR_CCW)) && (cur_ph == PH_11)) begin
            if (acc_next == substep_t'(STEPS_PER_DETENT)) begin
                cw_next = 1'b1;
            end else if (acc_next == -substep_t'(STEPS_PER_DETENT)) begin
                ccw_next = 1'b1;
            end
            acc_next = '0;
        end
    end

    // Next position: a load wins over a step; steps saturate or wrap at the bounds.
    always_comb begin
        value_next = value_reg;
        if (bus.load) begin
            value_next = bus.load_val;
        end else if (cw_next) begin
`ifdef QDEC_WRAP_EN
            value_next = (value_reg >= MAX_VAL) ? MIN_VAL : value_reg + CNT_W'(1);
`else
            value_next = (value_reg >= MAX_VAL) ? MAX_VAL : value_reg + CNT_W'(1);
`endif
        end else if (ccw_next) begin
`ifdef QDEC_WRAP_EN
            value_next = (value_reg <= MIN_VAL) ? MAX_VAL : value_reg - CNT_W'(1);
`else
            value_next = (value_reg <= MIN_VAL) ? MIN_VAL : value_reg - CNT_W'(1);
`endif
        end
    end

    // Register phase history, accumulator, pulses and the bounded value.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg     <= PH_11;
            acc_reg      <= '0;
            step_cw_reg  <= 1'b0;
            step_ccw_reg <= 1'b0;
            err_reg      <= 1'b0;
            value_reg    <= INIT_VAL;
            at_min_reg   <= (INIT_VAL == MIN_VAL);
            at_max_reg   <= (INIT_VAL == MAX_VAL);
        end else begin
            prev_reg     <= cur_ph;
            acc_reg      <= acc_next;
            step_cw_reg  <= cw_next;
            step_ccw_reg <= ccw_next;
            err_reg      <= err_next;
            value_reg    <= value_next;
            at_min_reg   <= (value_next == MIN_VAL);
            at_max_reg   <= (value_next == MAX_VAL);
        end
    end

    assign bus.step_cw  = step_cw_reg;
    assign bus.step_ccw = step_ccw_reg;
    assign bus.err      = err_reg;
    assign bus.value    = value_reg;
    assign bus.at_min   = at_min_reg;
    assign bus.at_max   = at_max_reg;
endmodule

// File: tb/tb_quad_encoder_decoder.sv
// tb_quad_encoder_decoder: directed test plan followed by a random encoder
// walk. A history-window model of the filters plus a position-arithmetic
// model of the decoder is checked against the DUT on every falling edge;
// directed sections add literal expectations. Honours QDEC_WRAP_EN.
module tb_quad_encoder_decoder;
    localparam int D     = 4;
    localparam int CNT_W = 8;
    localparam int MINV  = 0;
    localparam int MAXV  = 9;
    localparam int INITV = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    quad_encoder_decoder_if #(.CNT_W(CNT_W)) bus_if ();

    quad_encoder_decoder #(
        .DEBOUNCE_CYC (D),
        .CNT_W        (CNT_W),
        .MIN_VAL      (8'(MINV)),
        .MAX_VAL      (8'(MAXV)),
        .INIT_VAL     (8'(INITV))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic h_a [0:D+1];
    logic h_b [0:D+1];
    logic [1:0] mf;
    logic [1:0] m_prev;
    int   m_acc;
    bit   m_cw, m_ccw, m_err;
    int   m_value;
    bit   m_valid = 0;

    function automatic int pos_of(input logic [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin
        int  d;
        bit  flip_a, flip_b;
        if (rst) begin
            for (int j = 0; j <= D + 1; j++) begin
                h_a[j] = 1'b1;
                h_b[j] = 1'b1;
            end
            mf      = 2'b11;
            m_prev  = 2'b11;
            m_acc   = 0;
            m_cw    = 0;
            m_ccw   = 0;
            m_err   = 0;
            m_value = INITV;
            m_valid = 1;
        end else begin
            m_cw  = 0;
            m_ccw = 0;
            m_err = 0;
            if (mf != m_prev) begin
                d = (pos_of(mf) - pos_of(m_prev) + 4) % 4;
                if (d == 2) begin
                    m_err = 1;
                    m_acc = 0;
                end else begin
                    m_acc += (d == 1) ? 1 : -1;
                    if (mf == 2'b11) begin
                        if (m_acc == 4) m_cw = 1;
                        else if (m_acc == -4) m_ccw = 1;
                        m_acc = 0;
                    end
                end
            end
            if (bus_if.load) begin
                m_value = int'(bus_if.load_val);
            end else if (m_cw) begin
`ifdef QDEC_WRAP_EN
                m_value = (m_value == MAXV) ? MINV : m_value + 1;
`else
                m_value = (m_value == MAXV) ? MAXV : m_value + 1;
`endif
            end else if (m_ccw) begin
`ifdef QDEC_WRAP_EN
                m_value = (m_value == MINV) ? MAXV : m_value - 1;
`else
                m_value = (m_value == MINV) ? MINV : m_value - 1;
`endif
            end
            m_prev = mf;
            // a channel flips once the synchronized input has disagreed
            // with it on each of the last D clocks (raw delayed by two)
            flip_a = 1;
            flip_b = 1;
            for (int j = 1; j <= D; j++) begin
                if (h_a[j] == mf[1]) flip_a = 0;
                if (h_b[j] == mf[0]) flip_b = 0;
            end
            if (flip_a) mf[1] = ~mf[1];
            if (flip_b) mf[0] = ~mf[0];
            for (int j = D + 1; j > 0; j--) begin
                h_a[j] = h_a[j-1];
                h_b[j] = h_b[j-1];
            end
            h_a[0] = bus_if.enc_a;
            h_b[0] = bus_if.enc_b;
        end
    end

    // ---------------- per-cycle compare + event monitor ----------------
    int cw_cnt = 0, ccw_cnt = 0, err_cnt = 0, last_cw_cyc = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("step_cw",  int'(bus_if.step_cw),  int'(m_cw));
            chk("step_ccw", int'(bus_if.step_ccw), int'(m_ccw));
            chk("err",      int'(bus_if.err),      int'(m_err));
            chk("value",    int'(bus_if.value),    m_value);
            chk("at_min",   int'(bus_if.at_min),   int'(m_value == MINV));
            chk("at_max",   int'(bus_if.at_max),   int'(m_value == MAXV));
        end
        if (!rst) begin
            if (bus_if.step_cw) begin
                cw_cnt++;
                last_cw_cyc = cyc;
                $display("cycle %0d: step_cw  value=%0d", cyc, bus_if.value);
            end
            if (bus_if.step_ccw) begin
                ccw_cnt++;
                $display("cycle %0d: step_ccw value=%0d", cyc, bus_if.value);
            end
            if (bus_if.err) begin
                err_cnt++;
                $display("cycle %0d: err", cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [1:0] ab, input int hold);
        bus_if.enc_a = ab[1];
        bus_if.enc_b = ab[0];
        repeat (hold) @(negedge clk);
    endtask

    task automatic cw_detent();
        drive(2'b01, 10); drive(2'b00, 10); drive(2'b10, 10); drive(2'b11, 12);
    endtask

    task automatic ccw_detent();
        drive(2'b10, 10); drive(2'b00, 10); drive(2'b01, 10); drive(2'b11, 12);
    endtask

    task automatic do_load(input int v);
        bus_if.load     = 1'b1;
        bus_if.load_val = 8'(v);
        @(negedge clk);
        bus_if.load     = 1'b0;
    endtask

    int b_cw, b_ccw, b_err, t_edge, v0;
    int exp2 [10];
    int exp3, exp4, exp5;
    logic [1:0] ph_ab [4];
    int cur_pos, r, hold;

    initial begin
`ifdef QDEC_WRAP_EN
        exp2 = '{4, 3, 2, 1, 0, 9, 8, 7, 6, 5};
        exp3 = 6; exp4 = 7; exp5 = 8;
`else
        exp2 = '{4, 3, 2, 1, 0, 0, 0, 0, 0, 0};
        exp3 = 1; exp4 = 2; exp5 = 3;
`endif
        ph_ab = '{2'b11, 2'b01, 2'b00, 2'b10};
        bus_if.enc_a    = 1'b1;
        bus_if.enc_b    = 1'b1;
        bus_if.load     = 1'b0;
        bus_if.load_val = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_value", int'(bus_if.value), 5);
        chk("reset_at_min", int'(bus_if.at_min), 0);
        rst = 1'b0;
        drive(2'b11, 5);

        // 1: one clean CW detent, pulse 7 clocks after the final 11 edge
        $display("test 1: single CW detent");
        b_cw = cw_cnt; b_err = err_cnt;
        drive(2'b01, 10); drive(2'b00, 10); drive(2'b10, 10);
        t_edge = cyc;
        drive(2'b11, 20);
        chk("t1_cw_count", cw_cnt - b_cw, 1);
        chk("t1_latency", last_cw_cyc - t_edge, 7);
        chk("t1_value", int'(bus_if.value), 6);
        chk("t1_err_count", err_cnt - b_err, 0);

        // 2: ten CCW detents from 5
        $display("test 2: ten CCW detents");
        do_load(5);
        b_ccw = ccw_cnt;
        for (int i = 0; i < 10; i++) begin
            ccw_detent();
            chk("t2_value", int'(bus_if.value), exp2[i]);
        end
        chk("t2_ccw_count", ccw_cnt - b_ccw, 10);
        chk("t2_at_min", int'(bus_if.at_min), int'(exp2[9] == 0));

        // 3: half turn and back, then a full detent proves acc is clear
        $display("test 3: half turn reversal");
        v0 = int'(bus_if.value);
        b_cw = cw_cnt; b_ccw = ccw_cnt;
        drive(2'b01, 10); drive(2'b00, 10); drive(2'b01, 10); drive(2'b11, 15);
        chk("t3_no_steps", (cw_cnt - b_cw) + (ccw_cnt - b_ccw), 0);
        chk("t3_value_held", int'(bus_if.value), v0);
        cw_detent();
        chk("t3_after_cw", int'(bus_if.value), exp3);

        // 4: chatter on A around the 11->01 edge
        $display("test 4: chatter on enc_a");
        b_cw = cw_cnt; b_err = err_cnt;
        for (int k = 0; k < 10; k++) drive({logic'(k % 2), 1'b1}, 2);
        drive(2'b01, 10); drive(2'b00, 10); drive(2'b10, 10); drive(2'b11, 12);
        chk("t4_cw_count", cw_cnt - b_cw, 1);
        chk("t4_err_count", err_cnt - b_err, 0);
        chk("t4_value", int'(bus_if.value), exp4);

        // 5: illegal 11->00, recovery, then a clean detent
        $display("test 5: illegal transition");
        b_cw = cw_cnt; b_err = err_cnt;
        drive(2'b00, 10); drive(2'b10, 10); drive(2'b11, 12);
        chk("t5_err_count", err_cnt - b_err, 1);
        chk("t5_no_step", cw_cnt - b_cw, 0);
        cw_detent();
        chk("t5_cw_after", cw_cnt - b_cw, 1);
        chk("t5_value", int'(bus_if.value), exp5);

        // 6: load coincident with a CW pulse, then reset mid-detent
        $display("test 6: load vs step, reset mid-detent");
        drive(2'b01, 10); drive(2'b00, 10); drive(2'b10, 10);
        bus_if.enc_a = 1'b1; bus_if.enc_b = 1'b1;
        repeat (6) @(negedge clk);
        bus_if.load = 1'b1; bus_if.load_val = 8'd3;
        @(negedge clk);
        bus_if.load = 1'b0;
        chk("t6_cw_pulse", int'(bus_if.step_cw), 1);
        chk("t6_load_value", int'(bus_if.value), 3);
        drive(2'b11, 10);
        drive(2'b01, 10); drive(2'b00, 10);
        rst = 1'b1; bus_if.enc_a = 1'b1; bus_if.enc_b = 1'b1;
        @(negedge clk);
        chk("t6_rst_value", int'(bus_if.value), 5);
        chk("t6_rst_pulses", int'(bus_if.step_cw) + int'(bus_if.step_ccw) + int'(bus_if.err), 0);
        rst = 1'b0;
        b_cw = cw_cnt; b_ccw = ccw_cnt; b_err = err_cnt;
        drive(2'b11, 20);
        chk("t6_quiet_after", (cw_cnt - b_cw) + (ccw_cnt - b_ccw) + (err_cnt - b_err), 0);
        chk("t6_value_after", int'(bus_if.value), 5);

        // random walk: legal moves, illegal jumps, glitches, loads, resets
        $display("random walk");
        cur_pos = 0;
        for (int it = 0; it < 400; it++) begin
            r    = $urandom_range(0, 99);
            hold = $urandom_range(1, 12);
            if (r < 40)      cur_pos = (cur_pos + 1) % 4;
            else if (r < 75) cur_pos = (cur_pos + 3) % 4;
            else if (r < 80) cur_pos = (cur_pos + 2) % 4;
            else begin
                drive(ph_ab[cur_pos] ^ 2'($urandom_range(1, 2)), $urandom_range(1, 3));
            end
            if ($urandom_range(0, 19) == 0) begin
                bus_if.enc_a = ph_ab[cur_pos][1];
                bus_if.enc_b = ph_ab[cur_pos][0];
                do_load($urandom_range(MINV, MAXV));
            end
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1; cur_pos = 0;
                drive(2'b11, 1);
                rst = 1'b0;
            end
            drive(ph_ab[cur_pos], hold);
        end
        drive(ph_ab[cur_pos], 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
